// File: rtl/hwpe_stream_realign_addrgen.sv
// hwpe_stream_realign_addrgen
//
// Address generator placed in front of the source realigner on the HWPE load
// path. It walks a 2D transfer (nb_lines lines of line_length words, line
// starts line_stride bytes apart) and issues word-aligned TCDM load addresses.
// Each request carries the byte strobe and the first/last/last_packet/realign
// flags the realigner needs. A misaligned base address costs one extra word
// per line, since every line then straddles line_length+1 aligned words.
//
// Ports
//   clk_i          clock
//   rst_i          synchronous active-high reset
//   clear_i        synchronous soft clear, aborts any transfer (no done pulse)
//   start_i        start pulse; configuration is sampled while idle
//   base_addr_i    byte address of the first element
//   line_stride_i  byte distance between line starts (low bits must be zero)
//   line_length_i  words per line as seen by the consumer
//   nb_lines_i     number of lines
//   addr_o         word-aligned load address
//   addr_valid_o   request valid
//   addr_ready_i   request accepted by the memory side
//   strb_o         byte strobe of the current word
//   strb_valid_o   request handshake (addr_valid_o & addr_ready_i)
//   first_o        current word is the first of its line
//   last_o         current word is the last of its line
//   last_packet_o  current word is the last of the transfer
//   realign_o      transfer is misaligned, held until the next start
//   busy_o         transfer in progress
//   done_o         one-cycle pulse after the last request is accepted
//   cfg_err_o      stride had nonzero low bits at start, held until next start
module hwpe_stream_realign_addrgen #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic                    start_i,
  input  logic [ADDR_WIDTH-1:0]   base_addr_i,
  input  logic [ADDR_WIDTH-1:0]   line_stride_i,
  input  logic [CNT_WIDTH-1:0]    line_length_i,
  input  logic [CNT_WIDTH-1:0]    nb_lines_i,
  output logic [ADDR_WIDTH-1:0]   addr_o,
  output logic                    addr_valid_o,
  input  logic                    addr_ready_i,
  output logic [DATA_WIDTH/8-1:0] strb_o,
  output logic                    strb_valid_o,
  output logic                    first_o,
  output logic                    last_o,
  output logic                    last_packet_o,
  output logic                    realign_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    cfg_err_o
);

  localparam int unsigned Bytes = DATA_WIDTH / 8;
  localparam int unsigned OffW  = $clog2(Bytes);

  localparam logic [Bytes-1:0]      AllOnes   = '1;
  localparam logic [ADDR_WIDTH-1:0] AlignMask = {{(ADDR_WIDTH - OffW){1'b1}}, {OffW{1'b0}}};
  localparam logic [CNT_WIDTH:0]    WordOne   = {{CNT_WIDTH{1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]  LineOne   = {{(CNT_WIDTH - 1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   line_base_q;  // aligned address of the current line start
  logic [ADDR_WIDTH-1:0]   stride_q;
  logic [ADDR_WIDTH-1:0]   addr_q;       // last address driven in RUN, shown while idle
  logic [OffW-1:0]         off_q;
  logic                    realign_q;
  logic [CNT_WIDTH:0]      wpl_q;        // words fetched per line, one extra if misaligned
  logic [CNT_WIDTH-1:0]    nb_lines_q;
  logic [CNT_WIDTH:0]      word_cnt_q;
  logic [CNT_WIDTH-1:0]    line_cnt_q;
  logic                    done_q;
  logic                    cfg_err_q;

  // Start-time decode of the configuration
  logic [OffW-1:0]         start_off;
  logic                    start_realign;
  logic [CNT_WIDTH:0]      start_wpl;
  logic                    start_empty;

  // Run-time decode from the registered counters
  logic                    run;
  logic                    accept;
  logic                    is_first;
  logic                    is_last;
  logic                    is_last_line;
  logic [CNT_WIDTH+OffW:0] word_off;
  logic [ADDR_WIDTH-1:0]   addr_run;
  logic [Bytes-1:0]        head_strb;

  always_comb begin
    start_off     = base_addr_i[OffW-1:0];
    start_realign = |start_off;
    start_wpl     = {1'b0, line_length_i} + {{CNT_WIDTH{1'b0}}, start_realign};
    start_empty   = (line_length_i == '0) || (nb_lines_i == '0);
  end

  always_comb begin
    run          = (state_q == StRun);
    accept       = run & addr_ready_i;
    is_first     = (word_cnt_q == '0);
    is_last      = (word_cnt_q == (wpl_q - WordOne));
    is_last_line = (line_cnt_q == (nb_lines_q - LineOne));
    word_off     = {word_cnt_q, {OffW{1'b0}}};
    addr_run     = line_base_q + ADDR_WIDTH'(word_off);
    head_strb    = AllOnes << off_q;
  end

  always_comb begin
    addr_o        = run ? addr_run : addr_q;
    addr_valid_o  = run;
    strb_valid_o  = accept;
    first_o       = run & is_first;
    last_o        = run & is_last;
    last_packet_o = run & is_last & is_last_line;
    busy_o        = run;
    done_o        = done_q;
    realign_o     = realign_q;
    cfg_err_o     = cfg_err_q;
    // A misaligned line covers wpl >= 2 words, so first and last never coincide here
    strb_o        = AllOnes;
    if (run && realign_q) begin
      if (is_first) begin
        strb_o = head_strb;
      end else if (is_last) begin
        strb_o = ~head_strb;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      line_base_q <= '0;
      stride_q    <= '0;
      addr_q      <= '0;
      off_q       <= '0;
      realign_q   <= 1'b0;
      wpl_q       <= '0;
      nb_lines_q  <= '0;
      word_cnt_q  <= '0;
      line_cnt_q  <= '0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (run) begin
        addr_q <= addr_run;
      end
      if (clear_i) begin
        state_q    <= StIdle;
        word_cnt_q <= '0;
        line_cnt_q <= '0;
      end else begin
        case (state_q)
          StIdle: begin
            if (start_i) begin
              line_base_q <= base_addr_i & AlignMask;
              stride_q    <= line_stride_i & AlignMask;
              off_q       <= start_off;
              realign_q   <= start_realign;
              wpl_q       <= start_wpl;
              nb_lines_q  <= nb_lines_i;
              cfg_err_q   <= |line_stride_i[OffW-1:0];
              word_cnt_q  <= '0;
              line_cnt_q  <= '0;
              if (start_empty) begin
                done_q <= 1'b1;
              end else begin
                state_q <= StRun;
              end
            end
          end
          StRun: begin
            if (accept) begin
              if (!is_last) begin
                word_cnt_q <= word_cnt_q + WordOne;
              end else begin
                word_cnt_q  <= '0;
                line_cnt_q  <= line_cnt_q + LineOne;
                line_base_q <= line_base_q + stride_q;
                if (is_last_line) begin
                  state_q <= StIdle;
                  done_q  <= 1'b1;
                end
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hwpe_stream_realign_addrgen.sv
module tb_hwpe_stream_realign_addrgen;

  logic        clk = 1'b0;
  logic        rst, clear, start;
  logic [31:0] base_addr, line_stride;
  logic [15:0] line_length, nb_lines;
  logic [31:0] addr;
  logic        addr_valid, addr_ready;
  logic [3:0]  strb;
  logic        strb_valid, first, last, last_packet, realign, busy, done, cfg_err;

  hwpe_stream_realign_addrgen #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .CNT_WIDTH (16)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .clear_i      (clear),
    .start_i      (start),
    .base_addr_i  (base_addr),
    .line_stride_i(line_stride),
    .line_length_i(line_length),
    .nb_lines_i   (nb_lines),
    .addr_o       (addr),
    .addr_valid_o (addr_valid),
    .addr_ready_i (addr_ready),
    .strb_o       (strb),
    .strb_valid_o (strb_valid),
    .first_o      (first),
    .last_o       (last),
    .last_packet_o(last_packet),
    .realign_o    (realign),
    .busy_o       (busy),
    .done_o       (done),
    .cfg_err_o    (cfg_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int lp_cyc = -1;
  int done_cyc = -1;

  logic [31:0] obs_addr[$];
  logic [3:0]  obs_strb[$];
  logic [2:0]  obs_flg[$];
  logic [31:0] exp_addr[$];
  logic [3:0]  exp_strb[$];
  logic [2:0]  exp_flg[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Record every accepted request and every done pulse
  always @(negedge clk) begin
    if (strb_valid) begin
      obs_addr.push_back(addr);
      obs_strb.push_back(strb);
      obs_flg.push_back({first, last, last_packet});
      if (last_packet) lp_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic reset_queues();
    obs_addr.delete(); obs_strb.delete(); obs_flg.delete();
    exp_addr.delete(); exp_strb.delete(); exp_flg.delete();
  endtask

  // flags = {first, last, last_packet}
  task automatic push_exp(input logic [31:0] a, input logic [3:0] s, input logic [2:0] f);
    exp_addr.push_back(a);
    exp_strb.push_back(s);
    exp_flg.push_back(f);
  endtask

  task automatic check_seq(input string tag);
    check({tag, " count"}, obs_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      check($sformatf("%s addr[%0d]", tag, i), obs_addr[i], exp_addr[i]);
      check($sformatf("%s strb[%0d]", tag, i), obs_strb[i], exp_strb[i]);
      check($sformatf("%s flags[%0d]", tag, i), obs_flg[i], exp_flg[i]);
    end
  endtask

  // Returns #1 after the edge that samples start
  task automatic start_xfer(input logic [31:0] b, input logic [31:0] s,
                            input logic [15:0] len, input logic [15:0] lines);
    @(posedge clk); #1;
    base_addr   = b;
    line_stride = s;
    line_length = len;
    nb_lines    = lines;
    start       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    bit seen = 1'b0;
    for (int k = 0; k < bound && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) check("done timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  int d0;

  initial begin
    rst = 1'b1; clear = 1'b0; start = 1'b0; addr_ready = 1'b1;
    base_addr = '0; line_stride = '0; line_length = '0; nb_lines = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("reset addr", addr, 32'h0);
    check("reset strb", strb, 4'hF);
    check("reset ctrl", {addr_valid, strb_valid, first, last, last_packet, realign, busy, done,
                         cfg_err}, 9'h0);

    // Aligned 3x2
    reset_queues();
    start_xfer(32'h100, 32'h40, 16'd3, 16'd2);
    @(negedge clk);
    check("aligned latency", addr_valid, 1'b1);
    wait_done(50);
    push_exp(32'h100, 4'hF, 3'b100);
    push_exp(32'h104, 4'hF, 3'b000);
    push_exp(32'h108, 4'hF, 3'b010);
    push_exp(32'h140, 4'hF, 3'b100);
    push_exp(32'h144, 4'hF, 3'b000);
    push_exp(32'h148, 4'hF, 3'b011);
    check_seq("aligned");
    check("aligned done timing", done_cyc, lp_cyc + 1);
    check("aligned realign", realign, 1'b0);
    check("aligned idle", {busy, addr_valid}, 2'b00);
    check("aligned addr hold", addr, 32'h148);

    // Misaligned
    reset_queues();
    start_xfer(32'h101, 32'h0, 16'd2, 16'd1);
    wait_done(50);
    push_exp(32'h100, 4'hE, 3'b100);
    push_exp(32'h104, 4'hF, 3'b000);
    push_exp(32'h108, 4'h1, 3'b011);
    check_seq("misaligned");
    check("misaligned realign held", realign, 1'b1);

    // Backpressure on word 1
    reset_queues();
    start_xfer(32'h101, 32'h0, 16'd2, 16'd1);
    @(posedge clk); #1;
    addr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("stall addr %0d", k), addr, 32'h104);
      check($sformatf("stall strb %0d", k), strb, 4'hF);
      check($sformatf("stall hs %0d", k), {addr_valid, strb_valid}, 2'b10);
    end
    addr_ready = 1'b1;
    wait_done(50);
    push_exp(32'h100, 4'hE, 3'b100);
    push_exp(32'h104, 4'hF, 3'b000);
    push_exp(32'h108, 4'h1, 3'b011);
    check_seq("backpressure");

    // Zero configuration
    start_xfer(32'h100, 32'h40, 16'd4, 16'd0);
    @(negedge clk);
    check("zero cfg valid", addr_valid, 1'b0);
    check("zero cfg done", done, 1'b1);
    check("zero cfg busy", busy, 1'b0);
    @(negedge clk);
    check("zero cfg done pulse", done, 1'b0);

    // Start during RUN is ignored
    reset_queues();
    d0 = done_cnt;
    start_xfer(32'h200, 32'h10, 16'd2, 16'd2);
    base_addr   = 32'h300;
    line_length = 16'd5;
    start       = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(50);
    push_exp(32'h200, 4'hF, 3'b100);
    push_exp(32'h204, 4'hF, 3'b010);
    push_exp(32'h210, 4'hF, 3'b100);
    push_exp(32'h214, 4'hF, 3'b011);
    check_seq("restart ignored");
    check("restart done once", done_cnt - d0, 32'd1);

    // Clear after two requests
    reset_queues();
    d0 = done_cnt;
    start_xfer(32'h100, 32'h40, 16'd3, 16'd2);
    @(posedge clk);
    @(posedge clk); #1;
    addr_ready = 1'b0;
    clear      = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk);
    check("clear idle", {busy, addr_valid}, 2'b00);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    check("clear requests", obs_addr.size(), 32'd2);
    check("clear no done", done_cnt - d0, 32'd0);
    addr_ready = 1'b1;
    reset_queues();
    start_xfer(32'h100, 32'h40, 16'd3, 16'd2);
    wait_done(50);
    push_exp(32'h100, 4'hF, 3'b100);
    push_exp(32'h104, 4'hF, 3'b000);
    push_exp(32'h108, 4'hF, 3'b010);
    push_exp(32'h140, 4'hF, 3'b100);
    push_exp(32'h144, 4'hF, 3'b000);
    push_exp(32'h148, 4'hF, 3'b011);
    check_seq("after clear");

    // Stride with low bits set
    reset_queues();
    start_xfer(32'h0, 32'h41, 16'd2, 16'd2);
    @(negedge clk);
    check("stride cfg_err", cfg_err, 1'b1);
    wait_done(50);
    push_exp(32'h00, 4'hF, 3'b100);
    push_exp(32'h04, 4'hF, 3'b010);
    push_exp(32'h40, 4'hF, 3'b100);
    push_exp(32'h44, 4'hF, 3'b011);
    check_seq("stride");
    check("cfg_err held", cfg_err, 1'b1);

    // Single-word lines
    reset_queues();
    start_xfer(32'h10, 32'h8, 16'd1, 16'd3);
    @(negedge clk);
    check("single cfg_err clear", cfg_err, 1'b0);
    wait_done(50);
    push_exp(32'h10, 4'hF, 3'b110);
    push_exp(32'h18, 4'hF, 3'b110);
    push_exp(32'h20, 4'hF, 3'b111);
    check_seq("single word");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
